// File: rtl/change_dispenser_if.sv
// Coin payout bus between the vending controller/hopper side and the change dispenser.
// Signal names follow the established dispenser port names for drop-in compatibility.
interface change_dispenser_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [2:0]       change;
  logic             refill;
  logic             ack;
  logic             eject_l;
  logic             eject_s;
  logic             busy;
  logic             done;
  logic             short;
  logic [2:0]       remain;
  logic [CNT_W-1:0] cnt_l;
  logic [CNT_W-1:0] cnt_s;

  modport master (
    output start, change, refill, ack,
    input  eject_l, eject_s, busy, done, short, remain, cnt_l, cnt_s
  );

  modport slave (
    input  start, change, refill, ack,
    output eject_l, eject_s, busy, done, short, remain, cnt_l, cnt_s
  );
endinterface

// File: rtl/change_dispenser.sv
// Pays a 3-bit change amount out of a large-coin and a small-coin tube using a
// four-phase eject/ack handshake with the hopper; flags payouts the tubes cannot cover.
module change_dispenser #(
  parameter int unsigned LARGE_VAL  = 2,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned INIT_LARGE = 8,
  parameter int unsigned INIT_SMALL = 8
) (
  input  logic               clk,
  input  logic               rst,
  change_dispenser_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_EJECT,
    S_RELEASE,
    S_FINISH
  } state_t;

  localparam logic [2:0]       W_LARGE_VAL = 3'(LARGE_VAL);
  localparam logic [CNT_W-1:0] W_INIT_L    = CNT_W'(INIT_LARGE);
  localparam logic [CNT_W-1:0] W_INIT_S    = CNT_W'(INIT_SMALL);
  localparam logic [CNT_W-1:0] W_ONE       = CNT_W'(1);

  state_t           r_state;
  logic             r_eject_l;
  logic             r_eject_s;
  logic             r_done;
  logic             r_short;
  logic [2:0]       r_remain;
  logic [CNT_W-1:0] r_cnt_l;
  logic [CNT_W-1:0] r_cnt_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_eject_l <= 1'b0;
      r_eject_s <= 1'b0;
      r_done    <= 1'b0;
      r_short   <= 1'b0;
      r_remain  <= '0;
      r_cnt_l   <= W_INIT_L;
      r_cnt_s   <= W_INIT_S;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // Refill and start may coincide; PICK then sees the refilled counts.
          if (bus.refill) begin
            r_cnt_l <= W_INIT_L;
            r_cnt_s <= W_INIT_S;
          end
          if (bus.start) begin
            r_remain <= bus.change;
            r_short  <= 1'b0;
            r_state  <= S_PICK;
          end
        end
        S_PICK: begin
          if (r_remain == '0) begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else if ((r_remain >= W_LARGE_VAL) && (r_cnt_l != '0)) begin
            r_eject_l <= 1'b1;
            r_state   <= S_EJECT;
          end else if (r_cnt_s != '0) begin
            r_eject_s <= 1'b1;
            r_state   <= S_EJECT;
          end else begin
            r_short <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end
        end
        S_EJECT: begin
          // The active eject line doubles as the tube selection.
          if (bus.ack) begin
            r_eject_l <= 1'b0;
            r_eject_s <= 1'b0;
            if (r_eject_l) begin
              r_cnt_l  <= r_cnt_l - W_ONE;
              r_remain <= r_remain - W_LARGE_VAL;
            end else begin
              r_cnt_s  <= r_cnt_s - W_ONE;
              r_remain <= r_remain - 3'd1;
            end
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!bus.ack) begin
            r_state <= S_PICK;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.eject_l = r_eject_l;
  assign bus.eject_s = r_eject_s;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.short   = r_short;
  assign bus.remain  = r_remain;
  assign bus.cnt_l   = r_cnt_l;
  assign bus.cnt_s   = r_cnt_s;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a default 8/8 instance and a 1/1 instance,
// each with a hopper that acknowledges one cycle after an eject request.
module tb_change_dispenser;

  logic clk;
  logic rst;

  change_dispenser_if #(.CNT_W(4)) ifa ();
  change_dispenser_if #(.CNT_W(4)) ifb ();

  change_dispenser #(
    .LARGE_VAL (2),
    .CNT_W     (4),
    .INIT_LARGE(8),
    .INIT_SMALL(8)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  change_dispenser #(
    .LARGE_VAL (2),
    .CNT_W     (4),
    .INIT_LARGE(1),
    .INIT_SMALL(1)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Eject history encoded base 4: large = 1, small = 2, oldest coin most significant.
  int seq_a, seq_b;
  int done_a, done_b;
  int mutex_err;
  logic prev_el_a, prev_es_a, prev_el_b, prev_es_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ifa.ack <= ifa.eject_l | ifa.eject_s;
    ifb.ack <= ifb.eject_l | ifb.eject_s;
  end

  always @(negedge clk) begin
    if (ifa.eject_l && !prev_el_a) seq_a = seq_a * 4 + 1;
    if (ifa.eject_s && !prev_es_a) seq_a = seq_a * 4 + 2;
    if (ifb.eject_l && !prev_el_b) seq_b = seq_b * 4 + 1;
    if (ifb.eject_s && !prev_es_b) seq_b = seq_b * 4 + 2;
    if (ifa.done) done_a++;
    if (ifb.done) done_b++;
    if ((ifa.eject_l && ifa.eject_s) || (ifb.eject_l && ifb.eject_s)) mutex_err++;
    prev_el_a = ifa.eject_l;
    prev_es_a = ifa.eject_s;
    prev_el_b = ifb.eject_l;
    prev_es_b = ifb.eject_s;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input bit b);
    if (b) begin
      seq_b  = 0;
      done_b = 0;
    end else begin
      seq_a  = 0;
      done_a = 0;
    end
  endtask

  task automatic pulse_start(input bit b, input logic [2:0] amt);
    @(negedge clk);
    if (b) begin
      ifb.start  = 1'b1;
      ifb.change = amt;
    end else begin
      ifa.start  = 1'b1;
      ifa.change = amt;
    end
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  // cyc counts negedges from the PICK cycle after start to the cycle showing done.
  task automatic wait_done(input bit b, output int cyc);
    cyc = -1;
    for (int i = 0; i < 300; i++) begin
      if (b ? ifb.done : ifa.done) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
    if (cyc < 0) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic payout(input bit b, input logic [2:0] amt, output int cyc);
    clear_mon(b);
    pulse_start(b, amt);
    wait_done(b, cyc);
  endtask

  task automatic do_refill();
    @(negedge clk);
    ifa.refill = 1'b1;
    @(negedge clk);
    ifa.refill = 1'b0;
  endtask

  task automatic wait_ej_a(input logic lvl);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ifa.eject_l === lvl) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) check("eject_wait_timeout", 0, 1);
  endtask

  int cyc;

  initial begin
    rst        = 1'b0;
    ifa.start  = 1'b0;
    ifa.change = 3'd0;
    ifa.refill = 1'b0;
    ifb.start  = 1'b0;
    ifb.change = 3'd0;
    ifb.refill = 1'b0;
    ifa.ack    = 1'b0;
    ifb.ack    = 1'b0;
    seq_a = 0; seq_b = 0; done_a = 0; done_b = 0; mutex_err = 0;
    prev_el_a = 1'b0; prev_es_a = 1'b0; prev_el_b = 1'b0; prev_es_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("rst_busy",   int'(ifa.busy),    0);
    check("rst_done",   int'(ifa.done),    0);
    check("rst_short",  int'(ifa.short),   0);
    check("rst_eject",  int'({ifa.eject_l, ifa.eject_s}), 0);
    check("rst_remain", int'(ifa.remain),  0);
    check("rst_cnt_l",  int'(ifa.cnt_l),   8);
    check("rst_cnt_s",  int'(ifa.cnt_s),   8);
    check("rst_b_cnt_l", int'(ifb.cnt_l),  1);
    check("rst_b_cnt_s", int'(ifb.cnt_s),  1);

    // Change 5 from full tubes: L, L, S at 5 cycles per coin.
    payout(1'b0, 3'd5, cyc);
    check("p5_seq",    seq_a, 22);
    check("p5_cycles", cyc, 16);
    check("p5_cnt_l",  int'(ifa.cnt_l), 6);
    check("p5_cnt_s",  int'(ifa.cnt_s), 7);
    check("p5_remain", int'(ifa.remain), 0);
    check("p5_done",   done_a, 1);
    check("p5_short",  int'(ifa.short), 0);
    check("p5_busy",   int'(ifa.busy), 0);

    // Zero amount: done two cycles after start, nothing ejected.
    payout(1'b0, 3'd0, cyc);
    check("p0_cycles", cyc, 1);
    check("p0_seq",    seq_a, 0);
    check("p0_done",   done_a, 1);
    check("p0_cnt_l",  int'(ifa.cnt_l), 6);
    check("p0_cnt_s",  int'(ifa.cnt_s), 7);

    do_refill();
    check("refill1_cnt_l", int'(ifa.cnt_l), 8);
    check("refill1_cnt_s", int'(ifa.cnt_s), 8);

    // Drain the large tube, then pay from small coins only.
    for (int k = 0; k < 4; k++) payout(1'b0, 3'd4, cyc);
    check("drain_cnt_l", int'(ifa.cnt_l), 0);
    check("drain_cnt_s", int'(ifa.cnt_s), 8);
    payout(1'b0, 3'd3, cyc);
    check("p3_seq",    seq_a, 42);
    check("p3_cnt_s",  int'(ifa.cnt_s), 5);
    check("p3_short",  int'(ifa.short), 0);
    check("p3_remain", int'(ifa.remain), 0);

    // Tubes of one coin each cannot cover 7.
    payout(1'b1, 3'd7, cyc);
    check("p7_seq",    seq_b, 6);
    check("p7_short",  int'(ifb.short), 1);
    check("p7_remain", int'(ifb.remain), 4);
    check("p7_done",   done_b, 1);
    check("p7_cnt_l",  int'(ifb.cnt_l), 0);
    check("p7_cnt_s",  int'(ifb.cnt_s), 0);
    clear_mon(1'b1);
    pulse_start(1'b1, 3'd0);
    check("short_clr", int'(ifb.short), 0);
    wait_done(1'b1, cyc);
    check("short_clr_done", done_b, 1);

    // Start during EJECT must be ignored.
    do_refill();
    clear_mon(1'b0);
    pulse_start(1'b0, 3'd2);
    wait_ej_a(1'b1);
    ifa.start  = 1'b1;
    ifa.change = 3'd6;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_done(1'b0, cyc);
    repeat (3) @(negedge clk);
    check("ign_seq",    seq_a, 1);
    check("ign_cnt_l",  int'(ifa.cnt_l), 7);
    check("ign_cnt_s",  int'(ifa.cnt_s), 8);
    check("ign_done",   done_a, 1);
    check("ign_busy",   int'(ifa.busy), 0);
    do_refill();
    check("refill2_cnt_l", int'(ifa.cnt_l), 8);
    check("refill2_cnt_s", int'(ifa.cnt_s), 8);

    // Asynchronous reset during the second large eject.
    clear_mon(1'b0);
    pulse_start(1'b0, 3'd4);
    wait_ej_a(1'b1);
    wait_ej_a(1'b0);
    wait_ej_a(1'b1);
    check("pre_rst_cnt_l",  int'(ifa.cnt_l), 7);
    check("pre_rst_remain", int'(ifa.remain), 2);
    #1;
    rst = 1'b0;
    #1;
    check("arst_eject_l", int'(ifa.eject_l), 0);
    check("arst_busy",    int'(ifa.busy), 0);
    check("arst_remain",  int'(ifa.remain), 0);
    check("arst_cnt_l",   int'(ifa.cnt_l), 8);
    check("arst_cnt_s",   int'(ifa.cnt_s), 8);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_no_done", done_a, 0);
    check("arst_idle",    int'(ifa.busy), 0);

    check("eject_mutex", mutex_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "global timeout");
  end

endmodule
